adpll_lock_supervisor: RTL and testbench
========================================

// Module: adpll_lock_supervisor
// PURPOSE
//   Downstream of the ADPLL on REF_CLK. Qualifies the raw LOCK/POLARITY outputs into a
//   debounced LOCK_OK, detects loss of lock (LOCK drop or stuck POLARITY = frequency drift),
//   and drives PLL_RST (ORed into the ADPLL RESET at top level) to force re-acquisition.
//   Watches M and forces re-acquisition on multiplier change.
// PARAMETERS
//   QUAL_CYC    16   consecutive LOCK=1 cycles required before LOCK_OK
//   ACQ_TIMEOUT 256  max cycles in ACQUIRE before a forced relock
//   DRIFT_CYC   32   cycles without a POLARITY toggle while locked => loss
//   RST_HOLD    4    PLL_RST pulse width in cycles
// PORTS
//   REF_CLK     in   1  single clock, rising edge
//   RESET       in   1  synchronous, active-high reset
//   M           in   3  ADPLL multiplier setting (same bus as ADPLL.M)
//   LOCK        in   1  ADPLL raw lock flag, synchronous to REF_CLK
//   POLARITY    in   1  ADPLL phase-detector polarity, synchronous to REF_CLK
//   CLR_STICKY  in   1  clears LOSS_STICKY
//   PLL_RST     out  1  reset request to ADPLL
//   LOCK_OK     out  1  qualified lock
//   LOSS_STICKY out  1  set on any loss from LOCKED
//   RELOCK_CNT  out  4  number of RELOCK entries, saturates at 15
//   STATE       out  3  FSM state: IDLE=0 ACQUIRE=1 QUALIFY=2 LOCKED=3 LOST=4 RELOCK=5
// BEHAVIOUR
//   - Reset (sync): STATE=IDLE, PLL_RST=0, LOCK_OK=0, LOSS_STICKY=0, RELOCK_CNT=0, all counters 0.
//     RESET mid-operation: same values on that edge; PLL_RST drops that edge.
//   - LOCK, POLARITY, M registered once (LOCK_q, POL_q, M_q); all decisions use registered copies.
//   - All outputs registered; LOCK_OK=1 iff STATE=LOCKED; PLL_RST=1 iff STATE=RELOCK.
//   - IDLE: next edge -> ACQUIRE.
//   - ACQUIRE: cnt cleared on entry, +1 per cycle. LOCK_q=1 -> QUALIFY.
//     cnt==ACQ_TIMEOUT-1 and LOCK_q=0 -> RELOCK (LOSS_STICKY untouched).
//   - QUALIFY: cnt 0 on entry, +1 per cycle with LOCK_q=1; LOCK_q=0 -> ACQUIRE (timeout restarts).
//     cnt==QUAL_CYC-1 and LOCK_q=1 -> LOCKED. Net: LOCK_OK rises on edge QUAL_CYC+2, counting
//     the edge that first samples LOCK=1 as edge 1 (edge 18 at default).
//   - LOCKED: drift cnt cleared on entry and on every POL_q toggle, else +1.
//     LOCK_q=0 -> LOST; drift cnt==DRIFT_CYC-1 with no toggle -> LOST (DRIFT_CYC idle cycles).
//   - LOST: one cycle, LOCK_OK=0, LOSS_STICKY set on entry -> RELOCK.
//   - RELOCK: RELOCK_CNT +1 on entry (saturating 15); stays RST_HOLD cycles -> ACQUIRE.
//   - M change (M_q != previous M_q) in ACQUIRE/QUALIFY/LOCKED/LOST: -> ACQUIRE next edge,
//     no PLL_RST, no sticky, no RELOCK_CNT change; highest priority over other transitions.
//     In IDLE/RELOCK M change ignored (RELOCK completes; ACQUIRE entry restarts anyway).
//   - CLR_STICKY clears LOSS_STICKY; simultaneous set (LOST entry) wins.
//   - Counters sized $clog2 of their parameter; no wrap: each counter compares then leaves state.
// TESTING
//   1 LOCK=1 from edge 10, held -> STATE 1->2->3, LOCK_OK=1 on edge 27, PLL_RST never high.
//   2 LOCK never high -> RELOCK after 256 ACQUIRE cycles, PLL_RST high exactly 4 cycles,
//     RELOCK_CNT=1, LOSS_STICKY=0; repeat 20x -> RELOCK_CNT saturates at 15.
//   3 Locked, POLARITY toggling every 2 cycles, then held constant -> LOST after 32 cycles,
//     LOSS_STICKY=1, PLL_RST 4 cycles, then CLR_STICKY pulse -> LOSS_STICKY=0.
//   4 LOCK glitch low 1 cycle at QUALIFY cnt=10 -> back to ACQUIRE, requalify full 16 cycles.
//   5 Locked, M 1->3 -> STATE=ACQUIRE, LOCK_OK=0 two edges after M change, PLL_RST=0, sticky=0.
//   6 RESET asserted during RELOCK cycle 2 -> PLL_RST=0, STATE=IDLE, RELOCK_CNT=0 on that edge.

Source files
------------

// File: rtl/adpll_lock_supervisor_if.sv
// Signal bundle between the ADPLL-side stimulus (M/LOCK/POLARITY/CLR_STICKY) and the lock supervisor.
// The supervisor uses the slave view; whatever drives the ADPLL flags uses the master view.
interface adpll_lock_supervisor_if;
  logic [2:0] M;
  logic       LOCK;
  logic       POLARITY;
  logic       CLR_STICKY;
  logic       PLL_RST;
  logic       LOCK_OK;
  logic       LOSS_STICKY;
  logic [3:0] RELOCK_CNT;
  logic [2:0] STATE;

  modport master (
    output M, LOCK, POLARITY, CLR_STICKY,
    input  PLL_RST, LOCK_OK, LOSS_STICKY, RELOCK_CNT, STATE
  );

  modport slave (
    input  M, LOCK, POLARITY, CLR_STICKY,
    output PLL_RST, LOCK_OK, LOSS_STICKY, RELOCK_CNT, STATE
  );
endinterface

// File: rtl/adpll_lock_supervisor.sv
// Qualifies raw ADPLL LOCK/POLARITY into a debounced LOCK_OK, detects loss of lock or frequency
// drift, and pulses PLL_RST to force re-acquisition. Multiplier changes restart acquisition.
module adpll_lock_supervisor #(
  parameter int unsigned QUAL_CYC    = 16,
  parameter int unsigned ACQ_TIMEOUT = 256,
  parameter int unsigned DRIFT_CYC   = 32,
  parameter int unsigned RST_HOLD    = 4
) (
  input  logic                    REF_CLK,
  input  logic                    RESET,
  adpll_lock_supervisor_if.slave  bus
);

  localparam int unsigned ACQ_W   = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;
  localparam int unsigned QUAL_W  = (QUAL_CYC    > 1) ? $clog2(QUAL_CYC)    : 1;
  localparam int unsigned DRIFT_W = (DRIFT_CYC   > 1) ? $clog2(DRIFT_CYC)   : 1;
  localparam int unsigned HOLD_W  = (RST_HOLD    > 1) ? $clog2(RST_HOLD)    : 1;

  localparam logic [ACQ_W-1:0]   ACQ_LAST   = ACQ_W'(ACQ_TIMEOUT - 1);
  localparam logic [QUAL_W-1:0]  QUAL_LAST  = QUAL_W'(QUAL_CYC - 1);
  localparam logic [DRIFT_W-1:0] DRIFT_LAST = DRIFT_W'(DRIFT_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    QUALIFY = 3'd2,
    LOCKED  = 3'd3,
    LOST    = 3'd4,
    RELOCK  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               lock_q;
  logic               pol_q, pol_prev_q;
  logic [2:0]         m_q, m_prev_q;
  logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
  logic [QUAL_W-1:0]  qual_cnt_q, qual_cnt_d;
  logic [DRIFT_W-1:0] drift_cnt_q, drift_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               sticky_q, sticky_d;
  logic [3:0]         relock_cnt_q, relock_cnt_d;
  logic               lock_ok_q, pll_rst_q;
  logic               m_chg, pol_tgl, restart, sticky_set;

  assign m_chg   = (m_q != m_prev_q);
  assign pol_tgl = (pol_q != pol_prev_q);

  always_comb begin
    state_d      = state_q;
    acq_cnt_d    = acq_cnt_q;
    qual_cnt_d   = qual_cnt_q;
    drift_cnt_d  = drift_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    relock_cnt_d = relock_cnt_q;
    restart      = 1'b0;
    sticky_set   = 1'b0;

    // A multiplier change pre-empts every other transition outside IDLE/RELOCK.
    if (m_chg && (state_q inside {ACQUIRE, QUALIFY, LOCKED, LOST})) begin
      state_d = ACQUIRE;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (lock_q)                     state_d = QUALIFY;
          else if (acq_cnt_q == ACQ_LAST) state_d = RELOCK;
          else                            acq_cnt_d = acq_cnt_q + 1'b1;
        end
        QUALIFY: begin
          if (!lock_q)                     state_d = ACQUIRE;
          else if (qual_cnt_q == QUAL_LAST) state_d = LOCKED;
          else                             qual_cnt_d = qual_cnt_q + 1'b1;
        end
        LOCKED: begin
          if (!lock_q)                        state_d = LOST;
          else if (pol_tgl)                   drift_cnt_d = '0;
          else if (drift_cnt_q == DRIFT_LAST) state_d = LOST;
          else                                drift_cnt_d = drift_cnt_q + 1'b1;
        end
        LOST: state_d = RELOCK;
        RELOCK: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ACQUIRE;
          else                         hold_cnt_d = hold_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Entry actions are keyed on the destination so every path into a state behaves alike.
    if ((state_d != state_q) || restart) begin
      case (state_d)
        ACQUIRE: acq_cnt_d   = '0;
        QUALIFY: qual_cnt_d  = '0;
        LOCKED:  drift_cnt_d = '0;
        LOST:    sticky_set  = 1'b1;
        RELOCK: begin
          hold_cnt_d = '0;
          if (relock_cnt_q != 4'hF) relock_cnt_d = relock_cnt_q + 4'd1;
        end
        default: ;
      endcase
    end

    if (sticky_set)          sticky_d = 1'b1;
    else if (bus.CLR_STICKY) sticky_d = 1'b0;
    else                     sticky_d = sticky_q;
  end

  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      pol_q        <= 1'b0;
      pol_prev_q   <= 1'b0;
      m_q          <= '0;
      m_prev_q     <= '0;
      acq_cnt_q    <= '0;
      qual_cnt_q   <= '0;
      drift_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      sticky_q     <= 1'b0;
      relock_cnt_q <= '0;
      lock_ok_q    <= 1'b0;
      pll_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_q       <= bus.LOCK;
      pol_q        <= bus.POLARITY;
      pol_prev_q   <= pol_q;
      m_q          <= bus.M;
      m_prev_q     <= m_q;
      acq_cnt_q    <= acq_cnt_d;
      qual_cnt_q   <= qual_cnt_d;
      drift_cnt_q  <= drift_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      sticky_q     <= sticky_d;
      relock_cnt_q <= relock_cnt_d;
      lock_ok_q    <= (state_d == LOCKED);
      pll_rst_q    <= (state_d == RELOCK);
    end
  end

  assign bus.STATE       = state_q;
  assign bus.LOCK_OK     = lock_ok_q;
  assign bus.PLL_RST     = pll_rst_q;
  assign bus.LOSS_STICKY = sticky_q;
  assign bus.RELOCK_CNT  = relock_cnt_q;

endmodule

// File: tb/tb_adpll_lock_supervisor.sv
// Self-checking bench for adpll_lock_supervisor: randomized lock/glitch/drift/M scenarios
// compared per edge against an edge-timeline model derived from the lock supervisor rules.
module tb_adpll_lock_supervisor;
  localparam int QUAL  = 16;
  localparam int TMO   = 256;
  localparam int DRIFT = 32;
  localparam int HOLD  = 4;
  localparam int ST_IDLE = 0, ST_ACQ = 1, ST_QUAL = 2, ST_LOCKED = 3, ST_LOST = 4, ST_RELOCK = 5;

  logic REF_CLK = 1'b0;
  logic RESET   = 1'b1;

  adpll_lock_supervisor_if bus ();

  adpll_lock_supervisor #(
    .QUAL_CYC    (QUAL),
    .ACQ_TIMEOUT (TMO),
    .DRIFT_CYC   (DRIFT),
    .RST_HOLD    (HOLD)
  ) dut (
    .REF_CLK (REF_CLK),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 REF_CLK = ~REF_CLK;

  int   n_pass   = 0;
  int   n_checks = 0;
  int   edge_no  = 0;
  int   pol_mode = 0;  // 0: toggle every edge, 1: toggle every 2 edges, 2: hold
  logic pol_hist [0:8191];

  // Expected state when LOCK is first sampled high at edge s and then held (no other events).
  function automatic int lock_seq(input int e, input int s);
    if (e <= 0)        return ST_IDLE;
    if (e <= s)        return ST_ACQ;
    if (e <= s + QUAL) return ST_QUAL;
    return ST_LOCKED;
  endfunction

  task automatic tick();
    case (pol_mode)
      0: bus.POLARITY = ~bus.POLARITY;
      1: if (edge_no % 2 == 0) bus.POLARITY = ~bus.POLARITY;
      default: ;
    endcase
    @(posedge REF_CLK);
    #1;
    edge_no++;
    if (edge_no < 8192) pol_hist[edge_no] = bus.POLARITY;
  endtask

  task automatic do_reset(input logic [2:0] m);
    RESET          = 1'b1;
    bus.M          = m;
    bus.LOCK       = 1'b0;
    bus.POLARITY   = 1'b0;
    bus.CLR_STICKY = 1'b0;
    pol_mode       = 0;
    @(posedge REF_CLK);
    #1;
    RESET   = 1'b0;
    edge_no = 0;
  endtask

  task automatic test_reset();
    do_reset(3'd0);
    n_checks++; if (bus.STATE !== 3'd0) $display("FAIL rst_state got %0d want 0", bus.STATE); else n_pass++;
    n_checks++; if (bus.PLL_RST !== 1'b0) $display("FAIL rst_pll_rst got %b want 0", bus.PLL_RST); else n_pass++;
    n_checks++; if (bus.LOCK_OK !== 1'b0) $display("FAIL rst_lock_ok got %b want 0", bus.LOCK_OK); else n_pass++;
    n_checks++; if (bus.LOSS_STICKY !== 1'b0) $display("FAIL rst_sticky got %b want 0", bus.LOSS_STICKY); else n_pass++;
    n_checks++; if (bus.RELOCK_CNT !== 4'd0) $display("FAIL rst_relock_cnt got %0d want 0", bus.RELOCK_CNT); else n_pass++;
    tick();
    n_checks++; if (bus.STATE !== 3'(ST_ACQ)) $display("FAIL idle_exit got %0d want 1", bus.STATE); else n_pass++;
  endtask

  task automatic test_lock_acquire(input int s);
    int exp;
    do_reset(3'd0);
    for (int e = 1; e <= s + QUAL + 6; e++) begin
      bus.LOCK = (edge_no + 1 >= s);
      tick();
      exp = lock_seq(e, s);
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL acq_state s=%0d edge %0d got %0d want %0d", s, e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.LOCK_OK !== (exp == ST_LOCKED)) $display("FAIL acq_lock_ok s=%0d edge %0d got %b want %b", s, e, bus.LOCK_OK, exp == ST_LOCKED); else n_pass++;
      n_checks++; if (bus.PLL_RST !== 1'b0) $display("FAIL acq_pll_rst s=%0d edge %0d got %b want 0", s, e, bus.PLL_RST); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int exp, exp_rc, r;
    do_reset(3'd0);
    for (int e = 1; e <= 20 * (TMO + HOLD) + 10; e++) begin
      tick();
      r      = (e - 1) % (TMO + HOLD);
      exp    = (r < TMO) ? ST_ACQ : ST_RELOCK;
      exp_rc = (e >= TMO + 1) ? ((e - TMO - 1) / (TMO + HOLD) + 1) : 0;
      if (exp_rc > 15) exp_rc = 15;
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL tmo_state edge %0d got %0d want %0d", e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.PLL_RST !== (exp == ST_RELOCK)) $display("FAIL tmo_pll_rst edge %0d got %b want %b", e, bus.PLL_RST, exp == ST_RELOCK); else n_pass++;
      n_checks++; if (bus.RELOCK_CNT !== 4'(exp_rc)) $display("FAIL tmo_relock_cnt edge %0d got %0d want %0d", e, bus.RELOCK_CNT, exp_rc); else n_pass++;
      n_checks++; if (bus.LOSS_STICKY !== 1'b0) $display("FAIL tmo_sticky edge %0d got %b want 0", e, bus.LOSS_STICKY); else n_pass++;
    end
  endtask

  task automatic test_drift();
    int s, lk, hold_at, last_ref, lost_at, exp;
    logic done;
    s        = $urandom_range(1, 20);
    lk       = s + QUAL + 1;
    hold_at  = lk + $urandom_range(5, 40);
    lost_at  = -1;
    last_ref = lk;
    done     = 1'b0;
    do_reset(3'd0);
    pol_mode = 1;
    for (int e = 1; e <= lk + 200 && !done; e++) begin
      bus.LOCK = (edge_no + 1 >= s);
      if (edge_no + 1 >= hold_at) pol_mode = 2;
      tick();
      if (e < lk) exp = (e <= s) ? ST_ACQ : ST_QUAL;
      else if (lost_at < 0) begin
        // A polarity change is visible to the supervisor one edge after it is sampled.
        if (e > lk && pol_hist[e-1] !== pol_hist[e-2]) last_ref = e;
        if (e - last_ref == DRIFT) begin lost_at = e; exp = ST_LOST; end
        else exp = ST_LOCKED;
      end else if (e <= lost_at + HOLD) exp = ST_RELOCK;
      else begin exp = ST_ACQ; done = 1'b1; end
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL drift_state edge %0d got %0d want %0d", e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.LOCK_OK !== (exp == ST_LOCKED)) $display("FAIL drift_lock_ok edge %0d got %b want %b", e, bus.LOCK_OK, exp == ST_LOCKED); else n_pass++;
      n_checks++; if (bus.PLL_RST !== (exp == ST_RELOCK)) $display("FAIL drift_pll_rst edge %0d got %b want %b", e, bus.PLL_RST, exp == ST_RELOCK); else n_pass++;
      n_checks++; if (bus.LOSS_STICKY !== (lost_at >= 0)) $display("FAIL drift_sticky edge %0d got %b want %b", e, bus.LOSS_STICKY, lost_at >= 0); else n_pass++;
      n_checks++; if (bus.RELOCK_CNT !== ((lost_at >= 0 && e > lost_at) ? 4'd1 : 4'd0)) $display("FAIL drift_relock_cnt edge %0d got %0d", e, bus.RELOCK_CNT); else n_pass++;
    end
    n_checks++; if (!done) $display("FAIL drift_timeout got no loss/relock cycle want loss %0d edges after last toggle", DRIFT); else n_pass++;
    bus.CLR_STICKY = 1'b1;
    tick();
    bus.CLR_STICKY = 1'b0;
    n_checks++; if (bus.LOSS_STICKY !== 1'b0) $display("FAIL drift_clr_sticky got %b want 0", bus.LOSS_STICKY); else n_pass++;
    tick();
    n_checks++; if (bus.LOSS_STICKY !== 1'b0) $display("FAIL drift_clr_stays got %b want 0", bus.LOSS_STICKY); else n_pass++;
  endtask

  task automatic test_glitch(input int j);
    int s, g, exp;
    s = $urandom_range(1, 30);
    g = s + 1 + j;
    do_reset(3'd0);
    for (int e = 1; e <= g + QUAL + 6; e++) begin
      bus.LOCK = (edge_no + 1 >= s) && (edge_no + 1 != g);
      tick();
      if (e <= g)              exp = lock_seq(e, s);
      else if (e == g + 1)     exp = ST_ACQ;
      else if (e <= g + 1 + QUAL) exp = ST_QUAL;
      else                     exp = ST_LOCKED;
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL glitch_state j=%0d edge %0d got %0d want %0d", j, e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.LOCK_OK !== (exp == ST_LOCKED)) $display("FAIL glitch_lock_ok j=%0d edge %0d got %b want %b", j, e, bus.LOCK_OK, exp == ST_LOCKED); else n_pass++;
    end
  endtask

  task automatic test_m_change();
    int s, c, exp;
    s = $urandom_range(3, 20);
    c = s + QUAL + 1 + $urandom_range(3, 20);
    do_reset(3'd1);
    for (int e = 1; e <= c + QUAL + 6; e++) begin
      bus.LOCK = (edge_no + 1 >= s);
      bus.M    = (edge_no + 1 >= c) ? 3'd3 : 3'd1;
      tick();
      if (e <= c)                  exp = lock_seq(e, s);
      else if (e == c + 1)         exp = ST_ACQ;
      else if (e <= c + 1 + QUAL)  exp = ST_QUAL;
      else                         exp = ST_LOCKED;
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL mchg_state edge %0d got %0d want %0d", e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.LOCK_OK !== (exp == ST_LOCKED)) $display("FAIL mchg_lock_ok edge %0d got %b want %b", e, bus.LOCK_OK, exp == ST_LOCKED); else n_pass++;
      n_checks++; if (bus.PLL_RST !== 1'b0) $display("FAIL mchg_pll_rst edge %0d got %b want 0", e, bus.PLL_RST); else n_pass++;
      n_checks++; if (bus.LOSS_STICKY !== 1'b0) $display("FAIL mchg_sticky edge %0d got %b want 0", e, bus.LOSS_STICKY); else n_pass++;
      n_checks++; if (bus.RELOCK_CNT !== 4'd0) $display("FAIL mchg_relock_cnt edge %0d got %0d want 0", e, bus.RELOCK_CNT); else n_pass++;
    end
  endtask

  task automatic test_lock_drop();
    int s, d, exp;
    s = $urandom_range(1, 20);
    d = s + QUAL + 1 + $urandom_range(1, 10);
    do_reset(3'd0);
    for (int e = 1; e <= d + HOLD + 3; e++) begin
      bus.LOCK       = (edge_no + 1 >= s) && (edge_no + 1 < d);
      bus.CLR_STICKY = (edge_no + 1 == d + 1);  // clear coincides with the loss
      tick();
      if (e <= d)                exp = lock_seq(e, s);
      else if (e == d + 1)       exp = ST_LOST;
      else if (e <= d + 1 + HOLD) exp = ST_RELOCK;
      else                       exp = ST_ACQ;
      n_checks++; if (bus.STATE !== 3'(exp)) $display("FAIL drop_state edge %0d got %0d want %0d", e, bus.STATE, exp); else n_pass++;
      n_checks++; if (bus.PLL_RST !== (exp == ST_RELOCK)) $display("FAIL drop_pll_rst edge %0d got %b want %b", e, bus.PLL_RST, exp == ST_RELOCK); else n_pass++;
      n_checks++; if (bus.LOSS_STICKY !== (e > d)) $display("FAIL drop_sticky edge %0d got %b want %b", e, bus.LOSS_STICKY, e > d); else n_pass++;
      n_checks++; if (bus.RELOCK_CNT !== ((e > d + 1) ? 4'd1 : 4'd0)) $display("FAIL drop_relock_cnt edge %0d got %0d", e, bus.RELOCK_CNT); else n_pass++;
    end
    bus.CLR_STICKY = 1'b0;
  endtask

  task automatic test_reset_in_relock();
    do_reset(3'd0);
    for (int e = 1; e <= TMO + 2; e++) tick();
    n_checks++; if (bus.STATE !== 3'(ST_RELOCK)) $display("FAIL rrl_pre_state got %0d want 5", bus.STATE); else n_pass++;
    n_checks++; if (bus.PLL_RST !== 1'b1) $display("FAIL rrl_pre_pll_rst got %b want 1", bus.PLL_RST); else n_pass++;
    n_checks++; if (bus.RELOCK_CNT !== 4'd1) $display("FAIL rrl_pre_relock_cnt got %0d want 1", bus.RELOCK_CNT); else n_pass++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++; if (bus.STATE !== 3'(ST_IDLE)) $display("FAIL rrl_state got %0d want 0", bus.STATE); else n_pass++;
    n_checks++; if (bus.PLL_RST !== 1'b0) $display("FAIL rrl_pll_rst got %b want 0", bus.PLL_RST); else n_pass++;
    n_checks++; if (bus.RELOCK_CNT !== 4'd0) $display("FAIL rrl_relock_cnt got %0d want 0", bus.RELOCK_CNT); else n_pass++;
    tick();
    n_checks++; if (bus.STATE !== 3'(ST_ACQ)) $display("FAIL rrl_restart got %0d want 1", bus.STATE); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_acquire(10);
    test_lock_acquire($urandom_range(1, 200));
    test_timeout();
    test_drift();
    test_drift();
    test_glitch(10);
    test_glitch($urandom_range(0, 14));
    test_m_change();
    test_lock_drop();
    test_reset_in_relock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
